// File: rtl/mem_loader_pkg.sv
// Shared definitions for the memory loader: FSM state encoding and
// byte-packing constants used by the top and the byte packer.
package mem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);
  localparam int WORD_BITS      = 8 * BYTES_PER_WORD;

endpackage

// File: rtl/mem_loader_byte_packer.sv
// Assembles a little-endian 32-bit word from a byte stream. The first three
// bytes are shifted into a holding register; the fourth byte completes the
// word combinationally so the owner can register it on the same edge.
module mem_loader_byte_packer
  import mem_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 accept,
  input  logic [7:0]           byte_in,
  output logic                 word_valid,
  output logic [WORD_BITS-1:0] word
);

  logic [IDX_W-1:0]       idx;
  logic [WORD_BITS-9:0]   partial;

  // Track byte position and shift accepted bytes in; clear discards a partial word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      partial <= '0;
    end else if (clear) begin
      idx     <= '0;
      partial <= '0;
    end else if (accept) begin
      idx     <= idx + IDX_W'(1);
      partial <= {byte_in, partial[WORD_BITS-9:8]};
    end
  end

  // Word is complete on the handshake of the last byte of the group
  assign word_valid = accept && !clear && (idx == IDX_W'(BYTES_PER_WORD - 1));
  assign word       = {byte_in, partial};

endmodule

// File: rtl/mem_loader.sv
// Streams bytes into a word-addressed memory while holding the processor in
// reset. Owns the load FSM, the address/word counters and all registered
// outputs; byte assembly is delegated to mem_loader_byte_packer.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  core_rst_hold,
  output logic                  busy,
  output logic                  done
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] base_reg;
  logic [ADDR_WIDTH:0]   count_reg;
  logic [ADDR_WIDTH:0]   written;

  logic                  handshake;
  logic                  start_load;
  logic                  abort_load;
  logic                  pack_clear;
  logic                  word_valid;
  logic [WORD_BITS-1:0]  packed_word;

  // in_ready is only ever high in LOAD, so it alone qualifies the handshake
  assign handshake  = in_valid && in_ready;
  assign start_load = (state == ST_IDLE) && start;
  assign abort_load = (state == ST_LOAD) && abort;
  assign pack_clear = start_load || abort_load;

  mem_loader_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pack_clear),
    .accept     (handshake),
    .byte_in    (in_data),
    .word_valid (word_valid),
    .word       (packed_word)
  );

  // Load FSM with registered outputs; in_ready low while in LOAD marks the
  // cycle of the final write, after which the FSM reports completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      base_reg      <= '0;
      count_reg     <= '0;
      written       <= '0;
      in_ready      <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      core_rst_hold <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            base_reg      <= base_addr;
            count_reg     <= word_count;
            written       <= '0;
            core_rst_hold <= 1'b1;
            if (word_count == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state    <= ST_LOAD;
              in_ready <= 1'b1;
              busy     <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (abort) begin
            state         <= ST_IDLE;
            in_ready      <= 1'b0;
            busy          <= 1'b0;
            core_rst_hold <= 1'b0;
          end else if (!in_ready) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (word_valid) begin
            mem_we    <= 1'b1;
            mem_addr  <= base_reg + written[ADDR_WIDTH-1:0];
            mem_wdata <= DATA_WIDTH'(packed_word);
            written   <= written + (ADDR_WIDTH+1)'(1);
            if ((written + (ADDR_WIDTH+1)'(1)) == count_reg) begin
              in_ready <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          state         <= ST_IDLE;
          core_rst_hold <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
